// File: rtl/fila_ctrl.sv
// fila_ctrl: access controller for the fila byte queue.
// Round-robin arbitration of two producers, one consumer, one op in flight.
module fila_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic       clk_10KHz,
    input  logic       reset,
    input  logic       req_a_in,
    input  logic [7:0] data_a_in,
    output logic       ack_a_out,
    input  logic       req_b_in,
    input  logic [7:0] data_b_in,
    output logic       ack_b_out,
    input  logic       deq_req_in,
    output logic       deq_valid_out,
    output logic [7:0] deq_data_out,
    output logic [7:0] fila_data_out,
    output logic       fila_enqueue_out,
    output logic       fila_dequeue_out,
    input  logic [7:0] fila_data_in,
    input  logic [7:0] fila_len_in,
    output logic       full_out,
    output logic       empty_out,
    output logic       busy_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENQ,
        S_DEQ,
        S_SETTLE
    } state_t;

    localparam logic [7:0] LP_DEPTH = 8'(DEPTH);

    state_t     r_state;
    state_t     w_next;
    logic       r_last_b;
    logic       r_win_b;
    logic       r_prev_deq;
    logic       r_full;
    logic       r_empty;
    logic [7:0] r_fila_data;
    logic [7:0] r_deq_data;
    logic       w_grant_b;
    logic       w_do_deq;
    logic       w_do_enq;

    // Arbitration and next-state decision; draining beats filling.
    always_comb begin
        w_next    = r_state;
        w_grant_b = req_b_in && (!req_a_in || !r_last_b);
        w_do_deq  = deq_req_in && !r_empty;
        w_do_enq  = (req_a_in || req_b_in) && !r_full && !w_do_deq;
        unique case (r_state)
            S_IDLE: begin
                if (w_do_deq) begin
                    w_next = S_DEQ;
                end else if (w_do_enq) begin
                    w_next = S_ENQ;
                end
            end
            S_ENQ:    w_next = S_SETTLE;
            S_DEQ:    w_next = S_SETTLE;
            S_SETTLE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Winner capture, dequeued byte, and registered length flags.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            r_last_b    <= 1'b1;
            r_win_b     <= 1'b0;
            r_prev_deq  <= 1'b0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_fila_data <= 8'h00;
            r_deq_data  <= 8'h00;
        end else begin
            r_full     <= (fila_len_in >= LP_DEPTH);
            r_empty    <= (fila_len_in == 8'h00);
            r_prev_deq <= (r_state == S_DEQ);
            if (r_state == S_IDLE && w_do_enq) begin
                r_fila_data <= w_grant_b ? data_b_in : data_a_in;
                r_win_b     <= w_grant_b;
                r_last_b    <= w_grant_b;
            end
            if (r_state == S_DEQ) begin
                r_deq_data <= fila_data_in;
            end
        end
    end

    assign fila_enqueue_out = (r_state == S_ENQ);
    assign fila_dequeue_out = (r_state == S_DEQ);
    assign ack_a_out        = (r_state == S_ENQ) && !r_win_b;
    assign ack_b_out        = (r_state == S_ENQ) && r_win_b;
    assign deq_valid_out    = (r_state == S_SETTLE) && r_prev_deq;
    assign deq_data_out     = r_deq_data;
    assign fila_data_out    = r_fila_data;
    assign full_out         = r_full;
    assign empty_out        = r_empty;
    assign busy_out         = (r_state != S_IDLE);

endmodule
